// File: rtl/gate_sweep_pkg.sv
// Shared types and sizing helpers for the gate sweep sequencers.
package gate_sweep_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  function automatic int num_vec(input int n_in);
    return 1 << n_in;
  endfunction

  // A one-cycle settle still needs a 1-bit counter to hold the value 0.
  function automatic int cnt_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

  localparam int N_IN_DEF    = 3;
  localparam int SETTLE_DEF  = 1;
  localparam int NUM_VEC_DEF = num_vec(N_IN_DEF);
  localparam int CNT_W_DEF   = cnt_width(SETTLE_DEF);

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweep of a small combinational block with result capture.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [num_vec(N_IN)-1:0] expect_tt,
  input  logic                     dut_out,
  output logic [N_IN-1:0]          dut_in,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [N_IN:0]            err_count,
  output logic                     first_err_valid,
  output logic [N_IN-1:0]          first_err_vec
);

  localparam int                 NUM_VEC  = num_vec(N_IN);
  localparam int                 CNT_W    = cnt_width(SETTLE);
  localparam logic [CNT_W-1:0]   RELOAD   = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]    LAST_VEC = N_IN'(NUM_VEC - 1);

  state_t          state, state_n;
  logic [N_IN-1:0] vec, vec_n;
  logic [N_IN:0]   err_n;
  logic            tmr_load, tmr_dec, tmr_zero;
  logic            clear, cmp_en, mismatch, running_n;

  settle_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (RELOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign mismatch = (dut_out != expect_tt[vec]);

  always_comb begin
    state_n  = state;
    vec_n    = vec;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    clear    = 1'b0;
    cmp_en   = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n  = APPLY;
        vec_n    = '0;
        tmr_load = 1'b1;
        clear    = 1'b1;
      end
      APPLY: begin
        if (abort) begin
          state_n = IDLE;
          vec_n   = '0;
        end else if (tmr_zero) state_n = CHECK;
        else                   tmr_dec = 1'b1;
      end
      CHECK: begin
        // abort wins over the compare, so the current vector is never scored
        if (abort) begin
          state_n = IDLE;
          vec_n   = '0;
        end else begin
          cmp_en = 1'b1;
          if (vec == LAST_VEC) begin
            state_n = DONE;
            vec_n   = '0;
          end else begin
            state_n  = APPLY;
            vec_n    = vec + N_IN'(1);
            tmr_load = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    err_n     = clear ? '0 : err_count + (N_IN+1)'(cmp_en && mismatch);
    running_n = (state_n == APPLY) || (state_n == CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      vec    <= '0;
      dut_in <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      vec    <= vec_n;
      dut_in <= running_n ? vec_n : '0;
      busy   <= running_n;
      done   <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count       <= '0;
      pass            <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      err_count <= err_n;
      if (clear) begin
        pass            <= 1'b0;
        first_err_valid <= 1'b0;
        first_err_vec   <= '0;
      end else begin
        if (state_n == DONE) pass <= (err_n == '0);
        if (cmp_en && mismatch && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_vec   <= vec;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench: two sequencers (SETTLE=1 and SETTLE=3) sweeping an OR3 model.
module tb_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] expect_tt = 8'hFE;

  logic       start1 = 1'b0, abort1 = 1'b0, stuck1 = 1'b0, dut_out1;
  logic [2:0] dut_in1, fev1;
  logic [3:0] err1;
  logic       busy1, done1, pass1, fevv1;

  logic       start3 = 1'b0, abort3 = 1'b0, dut_out3;
  logic [2:0] dut_in3, fev3;
  logic [3:0] err3;
  logic       busy3, done3, pass3, fevv3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign dut_out1 = stuck1 ? 1'b0 : |dut_in1;
  assign dut_out3 = |dut_in3;

  gate_sweep_ctrl #(.N_IN(3), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .expect_tt(expect_tt), .dut_out(dut_out1), .dut_in(dut_in1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fevv1), .first_err_vec(fev1)
  );

  gate_sweep_ctrl #(.N_IN(3), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .expect_tt(expect_tt), .dut_out(dut_out3), .dut_in(dut_in3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_err_valid(fevv3), .first_err_vec(fev3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start1();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
  endtask

  task automatic follow1(input int from, input int upto);
    for (int k = from; k < upto; k++) begin
      check($sformatf("dut_in1 k=%0d", k), dut_in1, k >> 1);
      check($sformatf("busy1 k=%0d", k), busy1, 1);
      check($sformatf("done1 k=%0d", k), done1, 0);
      @(negedge clk);
    end
  endtask

  task automatic check_idle1(input string tag);
    check({tag, " dut_in"}, dut_in1, 0);
    check({tag, " busy"}, busy1, 0);
    check({tag, " done"}, done1, 0);
    check({tag, " pass"}, pass1, 0);
    check({tag, " err"}, err1, 0);
    check({tag, " fevv"}, fevv1, 0);
    check({tag, " fev"}, fev1, 0);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check_idle1("reset");
    check("reset busy3", busy3, 0);
    check("reset err3", err3, 0);
    rst_n = 1'b1;

    // good OR3, SETTLE=1
    pulse_start1();
    follow1(0, 16);
    check("s1 done", done1, 1);
    check("s1 pass", pass1, 1);
    check("s1 err", err1, 0);
    check("s1 fevv", fevv1, 0);
    check("s1 busy", busy1, 0);
    check("s1 dut_in", dut_in1, 0);
    @(negedge clk);
    check("s1 done pulse", done1, 0);
    check("s1 pass held", pass1, 1);

    // stuck-at-0 output
    stuck1 = 1'b1;
    pulse_start1();
    check("s2 pass cleared", pass1, 0);
    follow1(0, 16);
    check("s2 done", done1, 1);
    check("s2 pass", pass1, 0);
    check("s2 err", err1, 7);
    check("s2 fevv", fevv1, 1);
    check("s2 fev", fev1, 1);
    @(negedge clk);

    // SETTLE=3 good OR3
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      check($sformatf("dut_in3 k=%0d", k), dut_in3, k >> 2);
      check($sformatf("done3 k=%0d", k), done3, 0);
      @(negedge clk);
    end
    check("s3 done", done3, 1);
    check("s3 pass", pass3, 1);
    check("s3 err", err3, 0);
    @(negedge clk);
    check("s3 done pulse", done3, 0);

    // abort in CHECK of vec 4 (stuck so partial results are visible)
    stuck1 = 1'b1;
    pulse_start1();
    follow1(0, 9);
    check("s4 dut_in at abort", dut_in1, 4);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    check("s4 busy", busy1, 0);
    check("s4 dut_in", dut_in1, 0);
    check("s4 pass", pass1, 0);
    check("s4 err partial", err1, 3);
    check("s4 fevv", fevv1, 1);
    check("s4 fev", fev1, 1);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("s4 no done %0d", k), done1, 0);
      @(negedge clk);
    end
    stuck1 = 1'b0;
    pulse_start1();
    check("s4 err cleared", err1, 0);
    check("s4 fevv cleared", fevv1, 0);
    follow1(0, 16);
    check("s4 rerun done", done1, 1);
    check("s4 rerun pass", pass1, 1);
    check("s4 rerun err", err1, 0);
    @(negedge clk);

    // start re-pulsed while busy at vec 2
    pulse_start1();
    follow1(0, 4);
    start1 = 1'b1;
    check("s5 dut_in k=4", dut_in1, 2);
    check("s5 busy k=4", busy1, 1);
    @(negedge clk);
    start1 = 1'b0;
    follow1(5, 16);
    check("s5 done", done1, 1);
    check("s5 pass", pass1, 1);
    @(negedge clk);
    check("s5 no requeue", busy1, 0);

    // asynchronous reset at vec 5
    stuck1 = 1'b1;
    pulse_start1();
    follow1(0, 10);
    check("s6 dut_in pre", dut_in1, 5);
    check("s6 err pre", err1, 4);
    #2 rst_n = 1'b0;
    #1 check_idle1("s6 async");
    @(negedge clk);
    rst_n  = 1'b1;
    stuck1 = 1'b0;
    pulse_start1();
    follow1(0, 16);
    check("s6 done", done1, 1);
    check("s6 pass", pass1, 1);
    check("s6 err", err1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
